dot_seq: RTL

Sequencer for a shared bank of `dot_channel` lanes. It steps a programmable number of 288-element input rows through the bank one at a time. For each row it holds the bank's level-sensitive load until every lane reports valid, then pulses a write strobe so the caller captures the lane results. It sits between the layer controller (start/done) and the dot bank plus its result buffer.

---
 rtl/dot_pkg.sv | 21 ++
 rtl/dot_seq_wdog.sv | 25 ++
 rtl/dot_seq.sv | 102 ++++++++++
 3 files changed

// File: rtl/dot_pkg.sv
// Shared definitions for the dot bank sequencer: FSM states, bank geometry
// and row-length dependent widths.
package dot_pkg;

  localparam int DOT_ROWS  = 12;
  localparam int DOT_LANES = 32;
  localparam int DOT_LEN   = 288;

  // Element index / element count widths for a DOT_LEN row
  localparam int DOT_IDX_W = $clog2(DOT_LEN);
  localparam int DOT_CNT_W = $clog2(DOT_LEN + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CAP,
    GAP,
    FIN
  } dot_state_e;

endpackage

// File: rtl/dot_seq_wdog.sv
// LOAD-phase watchdog for dot_seq; only built when DOT_SEQ_TMO_EN is defined.
`ifdef DOT_SEQ_TMO_EN
module dot_seq_wdog #(
  parameter int TMO_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expire
);

  localparam int CW = $clog2(TMO_CYC + 1);

  logic [CW-1:0] cnt;

  // Counter is held at zero outside LOAD, so every LOAD entry starts fresh
  always_ff @(posedge clk) begin
    if (rst || !run) cnt <= '0;
    else             cnt <= cnt + CW'(1);
  end

  assign expire = run && (cnt == CW'(TMO_CYC - 1));

endmodule
`endif

// File: rtl/dot_seq.sv
// Row sequencer for the dot_channel bank: load, wait all-valid, capture, gap.
// Optional LOAD watchdog and err pulse with DOT_SEQ_TMO_EN.
module dot_seq
  import dot_pkg::*;
#(
  parameter int ROWS  = DOT_ROWS,
  parameter int LANES = DOT_LANES,
`ifdef DOT_SEQ_TMO_EN
  parameter int TMO_CYC = 1024,
`endif
  localparam int RW = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [RW:0]      n_rows,
  input  logic             abort,
  output logic             busy,
  output logic [RW-1:0]    row_idx,
  output logic             bank_load,
  input  logic [LANES-1:0] bank_valid,
  output logic             wr_en,
  output logic [RW-1:0]    wr_addr,
`ifdef DOT_SEQ_TMO_EN
  output logic             err,
`endif
  output logic             done
);

  dot_state_e  state, nxt;
  logic [RW:0] n_lat;
  logic [RW:0] n_clamp;
  logic        last;
  logic        tmo;

  assign n_clamp = (n_rows > (RW+1)'(ROWS)) ? (RW+1)'(ROWS) : n_rows;
  assign last    = ({1'b0, row_idx} == (n_lat - (RW+1)'(1)));

`ifdef DOT_SEQ_TMO_EN
  dot_seq_wdog #(.TMO_CYC(TMO_CYC)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .run    (state == LOAD),
    .expire (tmo)
  );
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (start) nxt = (n_rows == '0) ? FIN : LOAD;
      LOAD: if (&bank_valid) nxt = CAP;
      CAP:  nxt = last ? FIN : GAP;
      GAP:  nxt = LOAD;
      // A zero-row job enters FIN straight from IDLE and lingers one extra
      // cycle, so done still lands two edges after start is seen.
      FIN:  nxt = done ? IDLE : FIN;
      default: nxt = IDLE;
    endcase
    if (tmo)   nxt = IDLE;
    if (abort) nxt = IDLE;
  end

  // Outputs are registered from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      bank_load <= 1'b0;
      wr_en     <= 1'b0;
      done      <= 1'b0;
      wr_addr   <= '0;
      row_idx   <= '0;
      n_lat     <= '0;
    end else begin
      state     <= nxt;
      busy      <= (nxt != IDLE);
      bank_load <= (nxt == LOAD);
      wr_en     <= (nxt == CAP);
      done      <= (nxt == FIN) && (state != IDLE);
      if (nxt == CAP) wr_addr <= row_idx;
      if (abort) begin
        row_idx <= '0;
      end else if (state == IDLE && start) begin
        row_idx <= '0;
        n_lat   <= n_clamp;
      end else if (state == CAP && !last) begin
        row_idx <= row_idx + RW'(1);
      end
    end
  end

`ifdef DOT_SEQ_TMO_EN
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= tmo && !abort;
  end
`endif

endmodule
